// File: rtl/mem_a_pkg.sv
// Shared constants and FSM state type for the matrix-A memory writer and reader.
// Derived values follow the default geometry; the writer re-derives them from its own parameters.
package mem_a_pkg;

    localparam int N_DEF   = 20;
    localparam int L_DEF   = 4;
    localparam int W_DEF   = 64;
    localparam int U       = 2 * L_DEF;
    localparam int M       = (N_DEF + U - 1) / U;
    localparam int OVF     = N_DEF % U;
    localparam int WORD_W  = L_DEF * N_DEF * W_DEF;
    localparam int CHUNK_W = U * W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } wr_state_e;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/mem_a_chunk_placer.sv
// Combinational placement of one input chunk into the packed A-memory word.
// Element k of lane l lives at bits [(l*N-k+1)*W-1 -: W]; chunk element 1 sits in the chunk MSBs.
module mem_a_chunk_placer
    import mem_a_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int L      = L_DEF,
    parameter int W      = W_DEF,
    parameter int LANE_W = 3,
    parameter int CIDX_W = 2
) (
    input  logic [L*N*W-1:0]   word_i,
    input  logic [LANE_W-1:0]  lane_i,
    input  logic [CIDX_W-1:0]  chunk_idx_i,
    input  logic [2*L*W-1:0]   chunk_i,
    output logic [L*N*W-1:0]   word_o
);

    localparam int UNITS = 2 * L;
    localparam int BIT_W = $clog2(L * N * W);

    int               k_v;
    logic             take_v;
    logic [BIT_W-1:0] base_v;

    // Elements past N in the final chunk are padding and leave the word untouched.
    always_comb begin
        word_o = word_i;
        k_v    = 0;
        take_v = 1'b0;
        base_v = '0;
        for (int j = 1; j <= UNITS; j++) begin
            k_v    = (int'(chunk_idx_i) - 1) * UNITS + j;
            take_v = (k_v >= 1) && (k_v <= N) && (lane_i != '0);
            base_v = take_v ? BIT_W'((int'(lane_i) * N - k_v) * W) : '0;
            word_o[base_v +: W] = take_v ? chunk_i[(UNITS-j)*W +: W] : word_o[base_v +: W];
        end
    end

endmodule

// File: rtl/mem_a_chunk_writer.sv
// Writer side of the matrix-A memory: gathers L*M chunks per word, lanes L..1,
// then issues one single-cycle write and advances the address.
module mem_a_chunk_writer
    import mem_a_pkg::*;
#(
    parameter int no_of_elements_on_col_nos   = N_DEF,
    parameter int no_of_row_by_vector_modules = L_DEF,
    parameter int element_width               = W_DEF,
    parameter int no_of_units                 = 2 * no_of_row_by_vector_modules
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [31:0]                             base_addr,
    input  logic [31:0]                             no_of_words,
    input  logic                                    in_valid,
    input  logic [no_of_units*element_width-1:0]    in_chunk,
    output logic                                    in_ready,
    output logic                                    mem_wr_en,
    output logic [31:0]                             mem_wr_addr,
    output logic [no_of_row_by_vector_modules*no_of_elements_on_col_nos*element_width-1:0] mem_wr_data,
    output logic                                    busy,
    output logic                                    done
);

    localparam int NE     = no_of_elements_on_col_nos;
    localparam int NL     = no_of_row_by_vector_modules;
    localparam int EW     = element_width;
    localparam int CHUNKS = ceil_div(NE, no_of_units);
    localparam int WW     = NL * NE * EW;
    localparam int LANE_W = $clog2(NL + 1);
    localparam int CIDX_W = $clog2(CHUNKS + 1);

    wr_state_e          state_q;
    logic [LANE_W-1:0]  lane_q;
    logic [CIDX_W-1:0]  cidx_q;
    logic [31:0]        addr_q;
    logic [31:0]        words_left_q;
    logic [WW-1:0]      word_q;
    logic [WW-1:0]      placed_d;
    logic               in_ready_q;
    logic               mem_wr_en_q;
    logic               busy_q;
    logic               done_q;

    mem_a_chunk_placer #(
        .N      (NE),
        .L      (NL),
        .W      (EW),
        .LANE_W (LANE_W),
        .CIDX_W (CIDX_W)
    ) u_placer (
        .word_i      (word_q),
        .lane_i      (lane_q),
        .chunk_idx_i (cidx_q),
        .chunk_i     (in_chunk),
        .word_o      (placed_d)
    );

    // Load FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            cidx_q       <= '0;
            addr_q       <= 32'd0;
            words_left_q <= 32'd0;
            word_q       <= '0;
            in_ready_q   <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            mem_wr_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && (no_of_words != 32'd0)) begin
                        addr_q       <= base_addr;
                        words_left_q <= no_of_words;
                        lane_q       <= LANE_W'(NL);
                        cidx_q       <= CIDX_W'(1);
                        in_ready_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= FILL;
                    end else if (start) begin
                        done_q <= 1'b1;
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        word_q <= placed_d;
                        if (cidx_q == CIDX_W'(CHUNKS)) begin
                            cidx_q <= CIDX_W'(1);
                            if (lane_q == LANE_W'(1)) begin
                                in_ready_q  <= 1'b0;
                                mem_wr_en_q <= 1'b1;
                                state_q     <= WRITE;
                            end else begin
                                lane_q <= lane_q - LANE_W'(1);
                            end
                        end else begin
                            cidx_q <= cidx_q + CIDX_W'(1);
                        end
                    end
                end
                WRITE: begin
                    addr_q       <= addr_q + 32'd1;
                    words_left_q <= words_left_q - 32'd1;
                    if (words_left_q == 32'd1) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        lane_q     <= LANE_W'(NL);
                        cidx_q     <= CIDX_W'(1);
                        in_ready_q <= 1'b1;
                        state_q    <= FILL;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_wr_addr = addr_q;
    assign mem_wr_data = word_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
